// File: rtl/txn_frame_rx.sv
// Framed byte-stream receiver: SOF hunt, LEN check, XOR checksum, store-and-forward payload FIFO.
// Optional statistics counters (ok_cnt, hunt_drop) are built when TXN_FRAME_RX_STATS_EN is defined.
module txn_frame_rx #(
    parameter int          DEPTH   = 16,
    parameter int          MAX_LEN = 16,
    parameter logic [7:0]  SOF     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [7:0]  err_cnt,
`ifdef TXN_FRAME_RX_STATS_EN
    output logic [15:0] ok_cnt,
    output logic [15:0] hunt_drop,
`endif
    output logic [1:0]  dbg_state
);

    // Handshake: a byte moves on a rising edge where valid & ready are both high; valid,
    // once raised, and its data are held until accepted. in_ready never depends on in_valid.

    localparam int         AW        = $clog2(DEPTH);
    localparam int         PW        = AW + 1;
    localparam int         LW        = $clog2(MAX_LEN + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    if (MAX_LEN > DEPTH) begin : g_bad_len
        $error("txn_frame_rx: MAX_LEN must not exceed DEPTH");
    end
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("txn_frame_rx: DEPTH must be a power of 2 and >= 4");
    end

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHK     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [7:0]      chk_q, chk_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_err_q, frame_err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [8:0]      mem [DEPTH];

    logic            accept;
    logic            rd_fire;
    logic            spec_full;
    logic            last_byte;
    logic            wr_en;

    assign spec_full = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
    assign in_ready  = !((state_q == PAYLOAD) && spec_full);
    assign accept    = in_valid && in_ready;
    assign out_valid = (commit_ptr_q != rd_ptr_q);
    assign rd_fire   = out_valid && out_ready;
    assign out_data  = mem[rd_ptr_q[AW-1:0]][7:0];
    assign out_last  = mem[rd_ptr_q[AW-1:0]][8];
    assign last_byte = (cnt_q == (len_q - LW'(1)));

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q + (rd_fire ? PW'(1) : PW'(0));
        len_d        = len_q;
        cnt_d        = cnt_q;
        chk_d        = chk_q;
        frame_ok_d   = 1'b0;
        frame_err_d  = 1'b0;
        wr_en        = 1'b0;
        case (state_q)
            HUNT: begin
                if (accept && (in_data == SOF)) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    if ((in_data != 8'd0) && (in_data <= MAX_LEN_B)) begin
                        len_d   = in_data[LW-1:0];
                        chk_d   = in_data;
                        cnt_d   = '0;
                        state_d = PAYLOAD;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    chk_d    = chk_q ^ in_data;
                    cnt_d    = cnt_q + LW'(1);
                    if (last_byte) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (accept) begin
                    if (in_data == chk_q) begin
                        commit_ptr_d = wr_ptr_q;
                        frame_ok_d   = 1'b1;
                    end else begin
                        // Rollback discards every byte written since the last commit.
                        wr_ptr_d    = commit_ptr_q;
                        frame_err_d = 1'b1;
                    end
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
        err_cnt_d = (frame_err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            chk_q        <= '0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            chk_q        <= chk_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= {last_byte, in_data};
        end
    end

    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;
    assign dbg_state = state_q;

`ifdef TXN_FRAME_RX_STATS_EN
    logic [15:0] ok_cnt_q, ok_cnt_d;
    logic [15:0] hunt_drop_q, hunt_drop_d;

    always_comb begin
        ok_cnt_d    = ok_cnt_q + (frame_ok_d ? 16'd1 : 16'd0);
        hunt_drop_d = hunt_drop_q;
        if ((state_q == HUNT) && accept && (in_data != SOF) && (hunt_drop_q != 16'hFFFF)) begin
            hunt_drop_d = hunt_drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ok_cnt_q    <= '0;
            hunt_drop_q <= '0;
        end else begin
            ok_cnt_q    <= ok_cnt_d;
            hunt_drop_q <= hunt_drop_d;
        end
    end

    assign ok_cnt    = ok_cnt_q;
    assign hunt_drop = hunt_drop_q;
`endif

endmodule

// File: tb/tb_txn_frame_rx.sv
// Self-checking bench for txn_frame_rx: table of directed frames plus hand-written
// sequences for latency, backpressure and mid-frame reset.
module tb_txn_frame_rx;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        frame_ok;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic [1:0]  dbg_state;
`ifdef TXN_FRAME_RX_STATS_EN
    logic [15:0] ok_cnt;
    logic [15:0] hunt_drop;
`endif

    int checks   = 0;
    int failures = 0;
    int ok_seen  = 0;
    int err_seen = 0;
    logic [8:0] exp_q[$];

    txn_frame_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
`ifdef TXN_FRAME_RX_STATS_EN
        .ok_cnt    (ok_cnt),
        .hunt_drop (hunt_drop),
`endif
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: output handshakes and status pulses sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_ok) ok_seen++;
            if (frame_err) err_seen++;
            if (frame_ok && frame_err) begin
                failures++;
                $display("FAIL ok_err_both: got frame_ok=1 frame_err=1 expected at most one");
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out: got %0h expected no byte", {out_last, out_data});
                end else begin
                    check("out_byte", 16'({out_last, out_data}), 16'(exp_q.pop_front()));
                end
            end
        end
    end

    // drivers
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 16'(exp_q.size()), 16'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] b [0:7];
        int         nb;
        logic [8:0] pay [0:3];
        int         np;
        int         ok;
        int         err;
        logic [7:0] ecnt;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [7:0] chk;
        logic [7:0] b;

        // good frame, chk 03^11^22^33 = 03
        vecs[0] = '{b: '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 8'h00, 8'h00}, nb: 6,
                    pay: '{9'h011, 9'h022, 9'h133, 9'h000}, np: 3, ok: 1, err: 0, ecnt: 8'd0};
        // bad checksum, correct would be 32
        vecs[1] = '{b: '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hFF, 8'h00, 8'h00, 8'h00}, nb: 5,
                    pay: '{9'h000, 9'h000, 9'h000, 9'h000}, np: 0, ok: 0, err: 1, ecnt: 8'd1};
        // good frame after a rollback, chk 01^5A = 5B
        vecs[2] = '{b: '{8'hA5, 8'h01, 8'h5A, 8'h5B, 8'h00, 8'h00, 8'h00, 8'h00}, nb: 4,
                    pay: '{9'h15A, 9'h000, 9'h000, 9'h000}, np: 1, ok: 1, err: 0, ecnt: 8'd1};
        // leading junk ignored, then LEN=0
        vecs[3] = '{b: '{8'h00, 8'h7F, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, nb: 4,
                    pay: '{9'h000, 9'h000, 9'h000, 9'h000}, np: 0, ok: 0, err: 1, ecnt: 8'd2};
        // LEN=0x11 exceeds MAX_LEN
        vecs[4] = '{b: '{8'hA5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, nb: 2,
                    pay: '{9'h000, 9'h000, 9'h000, 9'h000}, np: 0, ok: 0, err: 1, ecnt: 8'd3};
        // SOF value as payload, chk 02^A5^A5 = 02
        vecs[5] = '{b: '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02, 8'h00, 8'h00, 8'h00}, nb: 5,
                    pay: '{9'h0A5, 9'h1A5, 9'h000, 9'h000}, np: 2, ok: 1, err: 0, ecnt: 8'd3};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;

        // reset
        @(posedge clk);
        #1;
        do_reset();
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_frame_ok", 16'(frame_ok), 16'd0);
        check("rst_frame_err", 16'(frame_err), 16'd0);
        check("rst_err_cnt", 16'(err_cnt), 16'd0);
        check("rst_in_ready", 16'(in_ready), 16'd1);

        // table
        for (int v = 0; v < 6; v++) begin
            ok_seen  = 0;
            err_seen = 0;
            for (int i = 0; i < vecs[v].np; i++) exp_q.push_back(vecs[v].pay[i]);
            for (int i = 0; i < vecs[v].nb; i++) send_byte(vecs[v].b[i]);
            wait_drain($sformatf("vec%0d_drain", v));
            check($sformatf("vec%0d_ok", v), 16'(ok_seen), 16'(vecs[v].ok));
            check($sformatf("vec%0d_err", v), 16'(err_seen), 16'(vecs[v].err));
            check($sformatf("vec%0d_err_cnt", v), 16'(err_cnt), 16'(vecs[v].ecnt));
        end

        // backpressure: fill all 16 entries with one committed frame
        out_ready = 1'b0;
        ok_seen   = 0;
        send_byte(8'hA5);
        send_byte(8'h10);
        chk = 8'h10;
        for (int i = 0; i < 16; i++) begin
            b   = 8'(i * 17);
            chk = chk ^ b;
            exp_q.push_back({(i == 15), b});
            send_byte(b);
        end
        send_byte(chk);
        check("lat_frame_ok", 16'(frame_ok), 16'd1);
        check("lat_out_valid", 16'(out_valid), 16'd1);
        check("lat_out_data", 16'(out_data), 16'h00);
        @(posedge clk);
        #1;
        check("lat_ok_one_cycle", 16'(frame_ok), 16'd0);

        // second frame stalls in PAYLOAD while the FIFO is full
        send_byte(8'hA5);
        send_byte(8'h04);
        in_valid = 1'b1;
        in_data  = 8'hC0;
        @(negedge clk);
        check("bp_in_ready_low", 16'(in_ready), 16'd0);
        repeat (3) @(negedge clk);
        check("bp_still_low", 16'(in_ready), 16'd0);
        check("bp_hold_data", 16'(out_data), 16'h00);
        check("bp_hold_valid", 16'(out_valid), 16'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_no_same_cycle_free", 16'(in_ready), 16'd0);
        chk = 8'h04;
        for (int i = 0; i < 4; i++) begin
            b   = 8'hC0 + 8'(i);
            chk = chk ^ b;
            exp_q.push_back({(i == 3), b});
            send_byte(b);
        end
        send_byte(chk);
        wait_drain("bp_drain");
        check("bp_ok_count", 16'(ok_seen), 16'd2);

        // reset in the middle of a payload
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        do_reset();
        check("mid_rst_out_valid", 16'(out_valid), 16'd0);
        check("mid_rst_err_cnt", 16'(err_cnt), 16'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_still_empty", 16'(out_valid), 16'd0);
        ok_seen  = 0;
        err_seen = 0;
        exp_q.push_back(9'h033);
        exp_q.push_back(9'h144);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h75);
        wait_drain("mid_rst_drain");
        check("mid_rst_ok", 16'(ok_seen), 16'd1);
        check("mid_rst_err", 16'(err_seen), 16'd0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
